// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one sequential divider among NUM_REQ requesters,
// short-circuits divide-by-zero and recovers from a hung divider with a watchdog reset.
module divider_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_accept,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_quotient,
  output logic [31:0]           resp_remainder,
  output logic [1:0]            resp_err,
  output logic                  div_enable,
  output logic [31:0]           div_a,
  output logic [31:0]           div_b,
  output logic                  div_rst_n,
  input  logic [31:0]           div_quotient,
  input  logic [31:0]           div_remainder,
  input  logic                  div_done
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RECOVER, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [ID_W-1:0]      cur_id_q, cur_id_d;
  logic [7:0]           wd_cnt_q, wd_cnt_d;
  logic                 recover_q, recover_d;
  logic [NUM_REQ-1:0]   req_accept_q, req_accept_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]      resp_id_q, resp_id_d;
  logic [31:0]          resp_quotient_q, resp_quotient_d;
  logic [31:0]          resp_remainder_q, resp_remainder_d;
  logic [1:0]           resp_err_q, resp_err_d;
  logic                 div_enable_q, div_enable_d;
  logic [31:0]          div_a_q, div_a_d;
  logic [31:0]          div_b_q, div_b_d;

  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      cand;
  logic [31:0]          sel_a, sel_b;

  // Search starts one past the last grant, so the last winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    sel_a = req_a[32*grant_idx +: 32];
    sel_b = req_b[32*grant_idx +: 32];
  end

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    cur_id_d         = cur_id_q;
    wd_cnt_d         = wd_cnt_q;
    recover_d        = 1'b0;
    req_accept_d     = '0;
    resp_valid_d     = 1'b0;
    resp_id_d        = resp_id_q;
    resp_quotient_d  = resp_quotient_q;
    resp_remainder_d = resp_remainder_q;
    resp_err_d       = resp_err_q;
    div_enable_d     = 1'b0;
    div_a_d          = div_a_q;
    div_b_d          = div_b_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          last_grant_d            = grant_idx;
          cur_id_d                = grant_idx;
          req_accept_d[grant_idx] = 1'b1;
          if (sel_b == '0) begin
            resp_valid_d     = 1'b1;
            resp_id_d        = grant_idx;
            resp_quotient_d  = '1;
            resp_remainder_d = sel_a;
            resp_err_d       = 2'b01;
            state_d          = S_RESP;
          end else begin
            div_a_d      = sel_a;
            div_b_d      = sel_b;
            div_enable_d = 1'b1;
            state_d      = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wd_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // A zero count marks the first WAIT cycle, where a stale done is ignored.
        if (wd_cnt_q != '0 && div_done) begin
          resp_valid_d     = 1'b1;
          resp_id_d        = cur_id_q;
          resp_quotient_d  = div_quotient;
          resp_remainder_d = div_remainder;
          resp_err_d       = 2'b00;
          state_d          = S_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
          if (wd_cnt_d == 8'(TIMEOUT_CYCLES)) begin
            recover_d = 1'b1;
            state_d   = S_RECOVER;
          end
        end
      end
      S_RECOVER: begin
        resp_valid_d     = 1'b1;
        resp_id_d        = cur_id_q;
        resp_quotient_d  = '0;
        resp_remainder_d = '0;
        resp_err_d       = 2'b10;
        state_d          = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      last_grant_q     <= ID_W'(NUM_REQ - 1);
      cur_id_q         <= '0;
      wd_cnt_q         <= '0;
      recover_q        <= 1'b0;
      req_accept_q     <= '0;
      resp_valid_q     <= 1'b0;
      resp_id_q        <= '0;
      resp_quotient_q  <= '0;
      resp_remainder_q <= '0;
      resp_err_q       <= '0;
      div_enable_q     <= 1'b0;
      div_a_q          <= '0;
      div_b_q          <= '0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      cur_id_q         <= cur_id_d;
      wd_cnt_q         <= wd_cnt_d;
      recover_q        <= recover_d;
      req_accept_q     <= req_accept_d;
      resp_valid_q     <= resp_valid_d;
      resp_id_q        <= resp_id_d;
      resp_quotient_q  <= resp_quotient_d;
      resp_remainder_q <= resp_remainder_d;
      resp_err_q       <= resp_err_d;
      div_enable_q     <= div_enable_d;
      div_a_q          <= div_a_d;
      div_b_q          <= div_b_d;
    end
  end

  assign req_accept     = req_accept_q;
  assign resp_valid     = resp_valid_q;
  assign resp_id        = resp_id_q;
  assign resp_quotient  = resp_quotient_q;
  assign resp_remainder = resp_remainder_q;
  assign resp_err       = resp_err_q;
  assign div_enable     = div_enable_q;
  assign div_a          = div_a_q;
  assign div_b          = div_b_q;
  assign div_rst_n      = rst_n & ~recover_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed scenarios plus random traffic, checked each cycle
// against a timeline model of grants, divider latency and responses.
module tb_divider_arbiter;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int TMO = 100;
  localparam int LAT = 68;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*32-1:0] req_a = '0;
  logic [NR*32-1:0] req_b = '0;
  logic [NR-1:0]   req_accept;
  logic            resp_valid;
  logic [IDW-1:0]  resp_id;
  logic [31:0]     resp_quotient, resp_remainder;
  logic [1:0]      resp_err;
  logic            div_enable, div_rst_n, div_done;
  logic [31:0]     div_a, div_b, div_quotient, div_remainder;

  divider_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_accept(req_accept), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder), .resp_err(resp_err),
    .div_enable(div_enable), .div_a(div_a), .div_b(div_b), .div_rst_n(div_rst_n),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit hang = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // Divider stand-in: done appears 67 cycles after the enable cycle, clears when idle.
  logic [31:0] d_a = '0, d_b = '0, d_q = '0, d_r = '0;
  logic        d_done = 1'b0;
  bit          d_busy = 1'b0;
  int          d_cnt = 0;
  always @(posedge clk) begin
    if (!div_rst_n) begin
      d_busy <= 1'b0; d_done <= 1'b0; d_cnt <= 0;
    end else if (div_enable && !d_busy) begin
      d_busy <= 1'b1; d_done <= 1'b0; d_cnt <= 0; d_a <= div_a; d_b <= div_b;
    end else if (d_busy) begin
      if (!hang && d_cnt == 65) begin
        d_busy <= 1'b0; d_done <= 1'b1; d_q <= d_a / d_b; d_r <= d_a % d_b;
      end else d_cnt <= d_cnt + 1;
    end else d_done <= 1'b0;
  end
  assign div_done      = d_done;
  assign div_quotient  = d_q;
  assign div_remainder = d_r;

  // Reference timeline: which cycle each output event must appear in.
  int m_last = NR-1, m_free = 0, m_acc_cyc = -1, m_acc_id = 0;
  int m_en_cyc = -1, m_rec_cyc = -1, m_resp_cyc = -1;
  logic [31:0] m_da = '0, m_db = '0, p_q = '0, p_r = '0, s_q = '0, s_r = '0;
  logic [1:0]  p_err = '0, s_err = '0;
  int          p_id = 0, s_id = 0;

  always @(posedge clk) begin : model
    int g;
    logic [31:0] a, b;
    if (!rst_n) begin
      m_last = NR-1; m_free = cyc+1; m_acc_cyc = -1; m_en_cyc = -1; m_rec_cyc = -1;
      m_resp_cyc = -1; s_q = '0; s_r = '0; s_err = '0; s_id = 0;
    end else if (cyc >= m_free && req_valid != '0) begin
      g = -1;
      for (int k = 1; k <= NR; k++)
        if (g < 0 && req_valid[(m_last+k)%NR]) g = (m_last+k)%NR;
      a = req_a[32*g +: 32];
      b = req_b[32*g +: 32];
      m_last = g; m_acc_cyc = cyc+1; m_acc_id = g; p_id = g;
      if (b == 0) begin
        p_q = 32'hFFFFFFFF; p_r = a; p_err = 2'b01; m_resp_cyc = cyc+1;
      end else begin
        m_en_cyc = cyc+1; m_da = a; m_db = b;
        if (hang) begin
          p_q = '0; p_r = '0; p_err = 2'b10;
          m_rec_cyc = cyc+1+TMO+1; m_resp_cyc = cyc+1+TMO+2;
        end else begin
          p_q = a / b; p_r = a % b; p_err = 2'b00; m_resp_cyc = cyc+1+LAT;
        end
      end
      m_free = m_resp_cyc+1;
    end
    cyc++;
    if (cyc == m_resp_cyc) begin
      s_q = p_q; s_r = p_r; s_err = p_err; s_id = p_id;
    end
  end

  always @(negedge clk) begin : compare
    logic [NR-1:0] e_acc;
    if (chk_en) begin
      e_acc = '0;
      if (cyc == m_acc_cyc) e_acc[m_acc_id] = 1'b1;
      chk("req_accept", 64'(req_accept), 64'(e_acc));
      chk("resp_valid", 64'(resp_valid), 64'(cyc == m_resp_cyc));
      chk("div_enable", 64'(div_enable), 64'(cyc == m_en_cyc));
      chk("div_rst_n", 64'(div_rst_n), 64'(rst_n && cyc != m_rec_cyc));
      chk("resp_id", 64'(resp_id), 64'(s_id));
      chk("resp_quotient", 64'(resp_quotient), 64'(s_q));
      chk("resp_remainder", 64'(resp_remainder), 64'(s_r));
      chk("resp_err", 64'(resp_err), 64'(s_err));
      chk("enable_vs_done", 64'(div_enable && div_done), 64'(0));
      if (cyc == m_en_cyc) begin
        chk("div_a", 64'(div_a), 64'(m_da));
        chk("div_b", 64'(div_b), 64'(m_db));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_accept(input int i, input bit drop, output int c);
    c = -1;
    for (int n = 0; n < 400 && c < 0; n++) begin
      if (req_accept[i]) begin
        c = cyc;
        if (drop) req_valid[i] = 1'b0;
      end else step();
    end
    if (c < 0) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_resp(output int c);
    c = -1;
    for (int n = 0; n < 400 && c < 0; n++) begin
      if (resp_valid) c = cyc;
      else step();
    end
    if (c < 0) chk("resp_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [31:0] rnd_b();
    int s;
    s = $urandom_range(15);
    if (s < 2) return 32'd0;
    if (s < 3) return 32'd1;
    if (s < 8) return 32'($urandom_range(15, 1));
    return $urandom;
  endfunction

  initial begin : global_timeout
    #600000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : driver
    int ca, cr, order[5];
    @(posedge clk);
    chk_en = 1'b1;
    step();
    chk("reset_accept", 64'(req_accept), 64'(0));
    chk("reset_divrstn", 64'(div_rst_n), 64'(0));
    chk("reset_quotient", 64'(resp_quotient), 64'(0));
    rst_n = 1'b1;
    repeat (3) step();

    put(1, 32'd100, 32'd7);
    wait_accept(1, 1'b1, ca);
    chk("single_accept", 64'(req_accept), 64'(4'b0010));
    wait_resp(cr);
    chk("single_latency", 64'(cr - ca), 64'(68));
    chk("single_id", 64'(resp_id), 64'(1));
    chk("single_q", 64'(resp_quotient), 64'(14));
    chk("single_r", 64'(resp_remainder), 64'(2));
    chk("single_err", 64'(resp_err), 64'(0));
    repeat (3) step();

    put(3, 32'h1234, 32'd0);
    wait_accept(3, 1'b1, ca);
    wait_resp(cr);
    chk("dz_latency", 64'(cr - ca), 64'(0));
    chk("dz_q", 64'(resp_quotient), 64'hFFFFFFFF);
    chk("dz_r", 64'(resp_remainder), 64'h1234);
    chk("dz_err", 64'(resp_err), 64'(1));
    repeat (3) step();

    hang = 1'b1;
    put(0, 32'd5, 32'd2);
    wait_accept(0, 1'b1, ca);
    wait_resp(cr);
    chk("wd_latency", 64'(cr - ca), 64'(TMO + 2));
    chk("wd_err", 64'(resp_err), 64'(2));
    chk("wd_q", 64'(resp_quotient), 64'(0));
    chk("wd_r", 64'(resp_remainder), 64'(0));
    step();
    hang = 1'b0;
    put(1, 32'd9, 32'd3);
    wait_accept(1, 1'b1, ca);
    wait_resp(cr);
    chk("post_wd_q", 64'(resp_quotient), 64'(3));
    chk("post_wd_r", 64'(resp_remainder), 64'(0));
    repeat (3) step();

    put(1, 32'd1000, 32'd3);
    wait_accept(1, 1'b1, ca);
    repeat (20) step();
    rst_n = 1'b0;
    step();
    chk("midrst_q", 64'(resp_quotient), 64'(0));
    chk("midrst_valid", 64'(resp_valid), 64'(0));
    rst_n = 1'b1;
    repeat (80) step();
    put(2, 32'd50, 32'd5);
    wait_accept(2, 1'b1, ca);
    wait_resp(cr);
    chk("midrst_latency", 64'(cr - ca), 64'(68));
    chk("midrst_id", 64'(resp_id), 64'(2));
    chk("midrst_next_q", 64'(resp_quotient), 64'(10));
    chk("midrst_next_r", 64'(resp_remainder), 64'(0));
    repeat (3) step();

    put(0, 32'd77, 32'd7);
    wait_accept(0, 1'b1, ca);
    wait_resp(cr);
    put(0, 32'd20, 32'd4);
    wait_accept(0, 1'b1, ca);
    chk("b2b_regrant", 64'(ca - cr), 64'(2));
    wait_resp(cr);
    chk("b2b_q", 64'(resp_quotient), 64'(5));
    repeat (3) step();

    do_reset(2);
    put(0, 32'hFFFFFFFF, 32'd1);
    put(1, 32'd1000, 32'd10);
    put(2, 32'd77, 32'd7);
    put(3, 32'd5, 32'd3);
    for (int k = 0; k < 5; k++) begin
      ca = -1;
      for (int n = 0; n < 400 && ca < 0; n++) begin
        if (req_accept != '0) begin
          ca = cyc;
          for (int i = 0; i < NR; i++) if (req_accept[i]) order[k] = i;
        end else step();
      end
      if (ca < 0) chk("fair_timeout", 64'(0), 64'(1));
      if (k == 4) req_valid = '0;
      wait_resp(cr);
      if (k == 0) begin
        chk("fair_first_q", 64'(resp_quotient), 64'hFFFFFFFF);
        chk("fair_first_r", 64'(resp_remainder), 64'(0));
      end
      step();
    end
    chk("fair_order", 64'({order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0], order[4][3:0]}),
        64'(20'h01230));
    repeat (3) step();

    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (req_accept[i]) begin
          req_valid[i] = 1'b0;
          if ($urandom_range(3) == 0) put(i, $urandom, rnd_b());
        end else if (!req_valid[i]) begin
          if ($urandom_range(19) == 0) put(i, $urandom, rnd_b());
        end else if ($urandom_range(199) == 0) req_valid[i] = 1'b0;
      end
      step();
    end
    req_valid = '0;
    repeat (150) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one 32-bit sequential restoring divider among NUM_REQ requesters, e.g. TDMA slot/frame index computation and timestamp scaling in the middleware.
- Arbitrates round-robin and sequences the divider's enable/done handshake.
- Short-circuits divide-by-zero without using the divider.
- Guards against a hung divider with a watchdog that resets the divider.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of resp_id. Must equal clog2(NUM_REQ), minimum 1.
- TIMEOUT_CYCLES, 100: WAIT cycles before the watchdog fires. Must be greater than 70; 8-bit counter, maximum 255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request. Level; requester holds it with operands stable until its req_accept.
- req_a  in  NUM_REQ*32  dividends; slice i is [32*i+31:32*i].
- req_b  in  NUM_REQ*32  divisors, same packing.
- req_accept  out  NUM_REQ  one-cycle pulse: operands of requester i captured.
- resp_valid  out  1  one-cycle result pulse.
- resp_id  out  ID_W  index of the requester the result belongs to.
- resp_quotient  out  32  quotient.
- resp_remainder  out  32  remainder.
- resp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout.
- div_enable  out  1  to divider enable.
- div_a  out  32  to divider dividend.
- div_b  out  32  to divider divisor.
- div_rst_n  out  1  to divider rst_n; equals rst_n AND NOT recover_pulse.
- div_quotient  in  32  from divider quotient.
- div_remainder  in  32  from divider remainder.
- div_done  in  1  from divider done.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State IDLE.
  - All outputs 0 except div_rst_n, which follows rst_n.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Watchdog counter 0.
  - Reset mid-operation abandons the operation and emits no response. The divider is reset by the same rst_n.
- States: IDLE, ISSUE, WAIT, RECOVER, RESP. All outputs are registered.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from last_grant+1 modulo NUM_REQ.
  - Latch that requester's a, b and id; update last_grant; pulse req_accept[id] next cycle.
  - If b == 0: go to RESP with quotient 32'hFFFFFFFF, remainder = a, err 01.
  - Otherwise drive div_a/div_b and go to ISSUE.
- ISSUE:
  - div_enable = 1 for exactly this one cycle.
  - Go to WAIT; clear the watchdog counter.
- WAIT:
  - div_enable = 0.
  - div_done is ignored in the first WAIT cycle.
  - Later, on div_done = 1: capture div_quotient/div_remainder, err 00, go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES, go to RECOVER.
- RECOVER:
  - div_rst_n low for exactly one cycle.
  - Result quotient 0, remainder 0, err 10; go to RESP.
- RESP:
  - resp_valid = 1 for one cycle with resp_id/data/err stable in that cycle; go to IDLE.
  - resp_* data holds until the next RESP; only resp_valid drops.
- Divider timing (fixed divider: 1 init, 64 calc, 1 done cycle): resp_valid is high exactly 68 cycles after the cycle in which req_accept is high.
- Divide-by-zero timing: req_accept and resp_valid are high in the same cycle.
- Throughput: one operation in flight. A new grant is possible in the IDLE cycle directly after RESP. By then div_done has already fallen, because the divider clears done in its first idle cycle without enable.
- Dropped requests: a requester that drops req_valid before accept is simply not granted. req_valid changes after grant do not affect the operation in flight.
- Same-cycle requests: these are arbitration only; fairness guarantees every continuously-valid requester is granted within NUM_REQ operations.
- Errors: resp_err values 11 are never produced.

Test Plan:
- Single request: requester 1 with a=100, b=7 -> req_accept=0010; 68 cycles later resp_valid with id 1, quotient 14, remainder 2, err 00.
- Divide-by-zero: requester 3 with a=0x1234, b=0 -> accept and resp in the same cycle; quotient 0xFFFFFFFF, remainder 0x1234, err 01; div_enable never asserted.
- Fairness: all four req_valid held high with distinct operands from reset -> grant order 0,1,2,3,0; each result correct (e.g. 0xFFFFFFFF/1 gives quotient 0xFFFFFFFF, remainder 0).
- Watchdog: a bench divider model that never raises done -> after 100 WAIT cycles, div_rst_n low for 1 cycle; resp err 10, quotient 0, remainder 0. A following request (a=9, b=3, real divider) returns 3/0.
- Reset mid-operation: rst_n low during WAIT -> no resp_valid; outputs zero; the next request from requester 2 (a=50, b=5) returns quotient 10, remainder 0 with correct latency.
- Back-to-back: requester 0 raises req_valid again in its RESP cycle -> re-granted in the following IDLE cycle; div_enable is never high while div_done is high.
